mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Purpose: cache-side and memory-side signal bundle for mem_arbiter.
// Latency: none; wires only.
// Backpressure: busywait signals stall the caches; m_busywait stalls the arbiter.
// Ports: i_* (i_cache fill), d_* (d_cache fill / write-back), m_* (shared main memory).
// The slave modport is the arbiter's view. The master modport is the environment's view:
// the caches plus the memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
);
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_readdata;
    logic              i_busywait;

    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_writedata;
    logic [DATA_W-1:0] d_readdata;
    logic              d_busywait;

    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_writedata;
    logic [DATA_W-1:0] m_readdata;
    logic              m_busywait;

    modport slave (
        input  i_read, i_addr, d_read, d_write, d_addr, d_writedata,
               m_readdata, m_busywait,
        output i_readdata, i_busywait, d_readdata, d_busywait,
               m_read, m_write, m_addr, m_writedata
    );

    modport master (
        output i_read, i_addr, d_read, d_write, d_addr, d_writedata,
               m_readdata, m_busywait,
        input  i_readdata, i_busywait, d_readdata, d_busywait,
               m_read, m_write, m_addr, m_writedata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Purpose: round-robin arbiter sharing one main memory between i_cache and d_cache.
// Latency: grant 1 cycle after request in IDLE; then memory time; then 1 DONE cycle.
// Backpressure: the ungranted side's busywait stays high; m_busywait stretches the grant.
// Ports: clk, rst (async, active-high); bus (mem_arbiter_if.slave) carries all cache/memory signals.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic              last_d, last_d_nxt;     // 1: d_cache got the most recent grant
    logic              grant_d, grant_d_nxt;   // side owning the current / just-finished transaction
    logic              m_read, m_read_nxt;
    logic              m_write, m_write_nxt;
    logic [ADDR_W-1:0] m_addr, m_addr_nxt;
    logic [DATA_W-1:0] m_wdata, m_wdata_nxt;
    logic [DATA_W-1:0] i_rdata, i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata, d_rdata_nxt;

    logic i_req, d_req, pick_d;

    assign i_req  = bus.i_read;
    // A simultaneous read and write from d_cache is handled as a write-back.
    assign d_req  = bus.d_read | bus.d_write;
    // On a tie, the side that did not win last time is served.
    assign pick_d = d_req & (~i_req | ~last_d);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            last_d  <= 1'b0;
            grant_d <= 1'b0;
            m_read  <= 1'b0;
            m_write <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state   <= state_nxt;
            last_d  <= last_d_nxt;
            grant_d <= grant_d_nxt;
            m_read  <= m_read_nxt;
            m_write <= m_write_nxt;
            m_addr  <= m_addr_nxt;
            m_wdata <= m_wdata_nxt;
            i_rdata <= i_rdata_nxt;
            d_rdata <= d_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_d_nxt  = last_d;
        grant_d_nxt = grant_d;
        m_read_nxt  = m_read;
        m_write_nxt = m_write;
        m_addr_nxt  = m_addr;
        m_wdata_nxt = m_wdata;
        i_rdata_nxt = i_rdata;
        d_rdata_nxt = d_rdata;

        case (state)
            IDLE: begin
                if (i_req | d_req) begin
                    grant_d_nxt = pick_d;
                    last_d_nxt  = pick_d;
                    if (pick_d) begin
                        m_write_nxt = bus.d_write;
                        m_read_nxt  = ~bus.d_write;
                        m_addr_nxt  = bus.d_addr;
                        m_wdata_nxt = bus.d_writedata;
                        state_nxt   = GRANT_D;
                    end else begin
                        m_read_nxt  = 1'b1;
                        m_write_nxt = 1'b0;
                        m_addr_nxt  = bus.i_addr;
                        state_nxt   = GRANT_I;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                // Any edge seen here is already at least one cycle into the grant.
                // The transaction runs to completion even if the requester drops its request.
                if (!bus.m_busywait) begin
                    if (m_read) begin
                        if (state == GRANT_D) begin
                            d_rdata_nxt = bus.m_readdata;
                        end else begin
                            i_rdata_nxt = bus.m_readdata;
                        end
                    end
                    m_read_nxt  = 1'b0;
                    m_write_nxt = 1'b0;
                    state_nxt   = DONE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.i_busywait  = i_req & ~((state == DONE) & ~grant_d);
    assign bus.d_busywait  = d_req & ~((state == DONE) &  grant_d);
    assign bus.i_readdata  = i_rdata;
    assign bus.d_readdata  = d_rdata;
    assign bus.m_read      = m_read;
    assign bus.m_write     = m_write;
    assign bus.m_addr      = m_addr;
    assign bus.m_writedata = m_wdata;
endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    localparam int AW = 28;
    localparam int DW = 128;

    localparam logic [DW-1:0] L08 = 128'hC0FFEE08_C0FFEE08_C0FFEE08_C0FFEE08;
    localparam logic [DW-1:0] L0C = 128'hC0FFEE0C_C0FFEE0C_C0FFEE0C_C0FFEE0C;
    localparam logic [DW-1:0] L10 = 128'hC0FFEE10_C0FFEE10_C0FFEE10_C0FFEE10;
    localparam logic [DW-1:0] L33 = 128'hC0FFEE33_C0FFEE33_C0FFEE33_C0FFEE33;
    localparam logic [DW-1:0] L50 = 128'hC0FFEE50_C0FFEE50_C0FFEE50_C0FFEE50;
    localparam logic [DW-1:0] L60 = 128'hC0FFEE60_C0FFEE60_C0FFEE60_C0FFEE60;
    localparam logic [DW-1:0] DA5 = {16{8'hA5}};
    localparam logic [DW-1:0] D5A = {16{8'h5A}};

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: 5-cycle latency, busywait high while a strobe is up
    // until the access is done. A write lands on the completing edge.
    logic [DW-1:0] mem [0:255];
    int            lat_cnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= {4{24'hC0FFEE, 8'(i)}};
            lat_cnt <= 0;
        end else if (bus.m_read || bus.m_write) begin
            if (lat_cnt != 5) lat_cnt <= lat_cnt + 1;
            else if (bus.m_write) mem[bus.m_addr[7:0]] <= bus.m_writedata;
        end else begin
            lat_cnt <= 0;
        end
    end

    assign bus.m_readdata = mem[bus.m_addr[7:0]];
    assign bus.m_busywait = (bus.m_read || bus.m_write) && (lat_cnt != 5);

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps cycles until the given side's busywait drops; returns cycles taken (capped).
    task automatic wait_bw(input bit side_d, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while ((side_d ? bus.d_busywait : bus.i_busywait) && n < 20);
    endtask

    typedef struct {
        bit            is_d;
        bit            rd;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        bit            exp_rd;
        bit            exp_wr;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t          vecs [7];
    logic [DW-1:0] exp_i, exp_d;
    logic [1:0]    st;
    int            n;

    initial begin
        vecs[0] = '{1'b0, 1'b1, 1'b0, 28'h10, '0,  1'b1, 1'b0, L10};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 28'h33, '0,  1'b1, 1'b0, L33};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 28'h20, DA5, 1'b0, 1'b1, '0};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 28'h20, '0,  1'b1, 1'b0, DA5};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 28'h40, D5A, 1'b0, 1'b1, '0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 28'h40, '0,  1'b1, 1'b0, D5A};
        vecs[6] = '{1'b0, 1'b1, 1'b0, 28'h20, '0,  1'b1, 1'b0, DA5};

        rst = 1'b0;
        bus.i_read = 1'b0; bus.i_addr = '0;
        bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_writedata = '0;
        #2 rst = 1'b1;
        #1;
        check("rst_m_read", 128'(bus.m_read), 128'(1'b0));
        check("rst_m_write", 128'(bus.m_write), 128'(1'b0));
        check("rst_m_addr", 128'(bus.m_addr), '0);
        check("rst_m_wdata", bus.m_writedata, '0);
        check("rst_i_rdata", bus.i_readdata, '0);
        check("rst_d_rdata", bus.d_readdata, '0);

        // Both sides request during reset; first tie goes to D.
        bus.i_read = 1'b1; bus.i_addr = 28'h0C;
        bus.d_read = 1'b1; bus.d_addr = 28'h08;
        #1;
        check("rst_i_busy", 128'(bus.i_busywait), 128'(1'b1));
        check("rst_d_busy", 128'(bus.d_busywait), 128'(1'b1));
        tick();
        rst = 1'b0;
        tick();
        check("tie_grant_d_read", 128'(bus.m_read), 128'(1'b1));
        check("tie_grant_d_addr", 128'(bus.m_addr), 128'(28'h08));
        check("tie_last_d", 128'(dut.last_d), 128'(1'b1));
        wait_bw(1'b1, n);
        check("tie_d_cycles", 128'(n), 128'(6));
        check("tie_d_rdata", bus.d_readdata, L08);
        check("tie_i_still_busy", 128'(bus.i_busywait), 128'(1'b1));
        bus.d_read = 1'b0;
        tick();
        check("tie_idle_gap", 128'(bus.m_read), 128'(1'b0));
        tick();
        check("tie_grant_i_addr", 128'(bus.m_addr), 128'(28'h0C));
        check("tie_last_i", 128'(dut.last_d), 128'(1'b0));
        wait_bw(1'b0, n);
        check("tie_i_cycles", 128'(n), 128'(6));
        check("tie_i_rdata", bus.i_readdata, L0C);
        bus.i_read = 1'b0;
        tick();
        exp_i = L0C;
        exp_d = L08;

        // Single-requester transactions.
        for (int k = 0; k < 7; k++) begin
            if (vecs[k].is_d) begin
                bus.d_read = vecs[k].rd; bus.d_write = vecs[k].wr;
                bus.d_addr = vecs[k].addr; bus.d_writedata = vecs[k].wdata;
            end else begin
                bus.i_read = vecs[k].rd; bus.i_addr = vecs[k].addr;
            end
            tick();
            check($sformatf("v%0d_m_read", k), 128'(bus.m_read), 128'(vecs[k].exp_rd));
            check($sformatf("v%0d_m_write", k), 128'(bus.m_write), 128'(vecs[k].exp_wr));
            check($sformatf("v%0d_m_addr", k), 128'(bus.m_addr), 128'(vecs[k].addr));
            if (vecs[k].exp_wr) check($sformatf("v%0d_m_wdata", k), bus.m_writedata, vecs[k].wdata);
            wait_bw(vecs[k].is_d, n);
            check($sformatf("v%0d_cycles", k), 128'(n), 128'(6));
            check($sformatf("v%0d_strobes_off", k), 128'(bus.m_read | bus.m_write), 128'(1'b0));
            if (vecs[k].exp_rd) begin
                if (vecs[k].is_d) exp_d = vecs[k].exp_rdata;
                else exp_i = vecs[k].exp_rdata;
            end
            check($sformatf("v%0d_i_rdata", k), bus.i_readdata, exp_i);
            check($sformatf("v%0d_d_rdata", k), bus.d_readdata, exp_d);
            bus.i_read = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
            tick();
        end

        // Both sides held: grants alternate, each waits one foreign transaction + 2 cycles.
        bus.i_read = 1'b1; bus.i_addr = 28'h11;
        bus.d_read = 1'b1; bus.d_addr = 28'h22;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                tick();
                n++;
            end while (!(bus.m_read || bus.m_write) && n < 20);
            check($sformatf("rr%0d_gap", k), 128'(n), (k == 0) ? 128'(1) : 128'(2));
            check($sformatf("rr%0d_addr", k), 128'(bus.m_addr), (k % 2 == 0) ? 128'(28'h22) : 128'(28'h11));
            wait_bw((k % 2) == 0, n);
            check($sformatf("rr%0d_cycles", k), 128'(n), 128'(6));
        end
        bus.i_read = 1'b0; bus.d_read = 1'b0;
        tick();

        // Requester withdraws while granted: transaction still completes and data lands.
        bus.i_read = 1'b1; bus.i_addr = 28'h60;
        tick();
        check("wd_grant", 128'(bus.m_read), 128'(1'b1));
        bus.i_read = 1'b0;
        #1;
        check("wd_busy_low", 128'(bus.i_busywait), 128'(1'b0));
        for (int c = 0; c < 6; c++) tick();
        check("wd_strobe_off", 128'(bus.m_read), 128'(1'b0));
        check("wd_i_rdata", bus.i_readdata, L60);
        tick();
        tick();
        check("wd_no_regrant", 128'(bus.m_read), 128'(1'b0));

        // Reset in the 3rd cycle of GRANT_D aborts without capture; request re-served after.
        bus.d_read = 1'b1; bus.d_addr = 28'h50;
        tick();
        check("rs_grant", 128'(bus.m_read), 128'(1'b1));
        tick();
        tick();
        rst = 1'b1;
        #1;
        st = dut.state;
        check("rs_m_read", 128'(bus.m_read), 128'(1'b0));
        check("rs_state", 128'(st), 128'(2'd0));
        check("rs_d_rdata", bus.d_readdata, '0);
        check("rs_d_busy", 128'(bus.d_busywait), 128'(1'b1));
        tick();
        rst = 1'b0;
        tick();
        check("rs_regrant", 128'(bus.m_read), 128'(1'b1));
        check("rs_regrant_addr", 128'(bus.m_addr), 128'(28'h50));
        wait_bw(1'b1, n);
        check("rs_cycles", 128'(n), 128'(6));
        check("rs_d_rdata_after", bus.d_readdata, L50);
        bus.d_read = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
